// File: rtl/bpu_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Kind codes, 2-bit counter states, table entry layout and FSM states.
package bpu_pkg;

  localparam logic [1:0] KIND_COND     = 2'd0;
  localparam logic [1:0] KIND_DIRECT   = 2'd1;
  localparam logic [1:0] KIND_INDIRECT = 2'd2;
  localparam logic [1:0] KIND_RSVD     = 2'd3;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
  localparam int TAG_MAX = 16;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic               slot;
    logic [29:0]        target;
    logic [1:0]         ctr;
  } entry_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

endpackage

// File: rtl/bpu_table.sv
// BTB storage: async lookup read, async read for update read-modify-write, one sync write.
// Storage is deliberately not reset; the top-level INIT sweep clears valid bits.
module bpu_table
  import bpu_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] lookup_idx,
  output entry_t           lookup_entry,
  input  logic [IDX_W-1:0] upd_idx,
  output entry_t           upd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  entry_t           wr_entry
);

  entry_t mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_entry;
  end

  assign lookup_entry = mem[lookup_idx];
  assign upd_entry    = mem[upd_idx];

endmodule

// File: rtl/bpu_predictor.sv
// Fetch-side branch predictor: BTB with 2-bit hysteresis counters, trained from EX.
// After reset an INIT sweep invalidates every entry before predictions are made.
module bpu_predictor
  import bpu_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_if,
  output logic [31:0] npc_pdc,
  output logic        ifnpc_pdc,
  output logic        bpu_ready,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_kind
);

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0]   lk_idx, up_idx, wr_idx;
  logic [TAG_MAX-1:0] lk_tag, up_tag;
  entry_t             lk_entry, up_entry, wr_entry;
  logic               wr_en;
  logic               lk_hit, up_match, up_eff_taken, run;
  logic [31:0]        fall_through;
  logic               unused_bits;

  assign unused_bits = ^{upd_pc[31:IDX_W+TAG_W+3], upd_pc[1:0], upd_target[1:0]};

  assign lk_idx = pc_if[IDX_W+2:3];
  assign lk_tag = TAG_MAX'(pc_if[IDX_W+TAG_W+2:IDX_W+3]);
  assign up_idx = upd_pc[IDX_W+2:3];
  assign up_tag = TAG_MAX'(upd_pc[IDX_W+TAG_W+2:IDX_W+3]);

  bpu_table #(.IDX_W(IDX_W)) u_table (
    .clk          (clk),
    .lookup_idx   (lk_idx),
    .lookup_entry (lk_entry),
    .upd_idx      (up_idx),
    .upd_entry    (up_entry),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_entry     (wr_entry)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign bpu_ready = run;

  // Lookup: a slot-0 entry covers only the first instruction of the group.
  assign fall_through = {pc_if[31:3] + 29'd1, 3'b000};
  assign lk_hit = run && lk_entry.valid && (lk_entry.tag == lk_tag) &&
                  (lk_entry.slot >= pc_if[2]) && lk_entry.ctr[1];
  assign npc_pdc   = lk_hit ? {lk_entry.target, 2'b00} : fall_through;
  assign ifnpc_pdc = lk_hit;

  // Update path; unconditional and indirect jumps always count as taken.
  assign up_match     = up_entry.valid && (up_entry.tag == up_tag) && (up_entry.slot == upd_pc[2]);
  assign up_eff_taken = upd_taken || (upd_kind != KIND_COND);

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = up_idx;
    wr_entry = up_entry;
    if (!run) begin
      wr_en          = 1'b1;
      wr_idx         = cnt_q;
      wr_entry       = '0;
    end else if (upd_valid && (upd_kind != KIND_RSVD)) begin
      if (up_match) begin
        wr_en        = 1'b1;
        wr_entry.ctr = up_eff_taken ? ctr_inc(up_entry.ctr) : ctr_dec(up_entry.ctr);
        if (upd_taken) wr_entry.target = upd_target[31:2];
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = up_tag;
        wr_entry.slot   = upd_pc[2];
        wr_entry.target = upd_target[31:2];
        wr_entry.ctr    = (upd_kind != KIND_COND) ? CTR_ST : CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_bpu_predictor.sv
// Directed bench for bpu_predictor: reset/INIT timing, training, hysteresis, aliasing, wrap.
module tb_bpu_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_if;
  logic [31:0] npc_pdc;
  logic        ifnpc_pdc;
  logic        bpu_ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_kind;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpu_predictor dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc_if      (pc_if),
    .npc_pdc    (npc_pdc),
    .ifnpc_pdc  (ifnpc_pdc),
    .bpu_ready  (bpu_ready),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_kind   (upd_kind)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] e_npc,
                      input logic e_tk);
    pc_if = pc;
    #1;
    chk({tag, "_npc"}, npc_pdc, e_npc);
    chk({tag, "_tk"}, {31'd0, ifnpc_pdc}, {31'd0, e_tk});
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [1:0] kind,
                     input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_kind   = kind;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic init_sweep(input string tag);
    int low_cnt;
    low_cnt = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (!bpu_ready) low_cnt++;
      if (i == 63) chk({tag, "_ready_c63"}, {31'd0, bpu_ready}, 32'd0);
    end
    chk({tag, "_ready_c64"}, {31'd0, bpu_ready}, 32'd1);
    chk({tag, "_low_cycles"}, low_cnt, 32'd63);
  endtask

  initial begin
    rstn       = 1'b0;
    pc_if      = 32'h1c000000;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    upd_kind   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    look("rst", 32'h1c000000, 32'h1c000008, 1'b0);
    chk("rst_ready", {31'd0, bpu_ready}, 32'd0);

    // Release reset with an update held for all of INIT: it must be dropped.
    upd_valid  = 1'b1;
    upd_pc     = 32'h1c000020;
    upd_taken  = 1'b1;
    upd_kind   = 2'd1;
    upd_target = 32'h1c000200;
    rstn       = 1'b1;
    pc_if      = 32'h1c000020;
    #1;
    chk("init_tk", {31'd0, ifnpc_pdc}, 32'd0);
    init_sweep("init");
    upd_valid = 1'b0;
    look("init_upd_ignored", 32'h1c000020, 32'h1c000028, 1'b0);
    look("run_miss", 32'h1c000000, 32'h1c000008, 1'b0);

    // Train slot 1; same-cycle lookup of the same index sees the old (empty) entry.
    upd_valid  = 1'b1;
    upd_pc     = 32'h1c000004;
    upd_taken  = 1'b1;
    upd_kind   = 2'd0;
    upd_target = 32'h1c000100;
    look("train_same_cyc", 32'h1c000000, 32'h1c000008, 1'b0);
    tick();
    upd_valid = 1'b0;
    look("train_s0", 32'h1c000000, 32'h1c000100, 1'b1);
    look("train_s1", 32'h1c000004, 32'h1c000100, 1'b1);
    look("train_next", 32'h1c000008, 32'h1c000010, 1'b0);
    look("alias", 32'h1c000204, 32'h1c000208, 1'b0);

    // Hysteresis: 10 -> 01 -> 10 -> 11, saturate, then back down.
    upd(32'h1c000004, 1'b0, 2'd0, 32'h0);
    look("hys_01", 32'h1c000004, 32'h1c000008, 1'b0);
    upd(32'h1c000004, 1'b1, 2'd0, 32'h1c000100);
    look("hys_10", 32'h1c000004, 32'h1c000100, 1'b1);
    upd(32'h1c000004, 1'b1, 2'd0, 32'h1c000100);
    upd(32'h1c000004, 1'b1, 2'd0, 32'h1c000100);
    upd(32'h1c000004, 1'b1, 2'd0, 32'h1c000100);
    upd(32'h1c000004, 1'b1, 2'd0, 32'h1c000183);
    look("hys_sat_tgt", 32'h1c000004, 32'h1c000180, 1'b1);
    upd(32'h1c000004, 1'b0, 2'd0, 32'h0);
    look("hys_sat_dn1", 32'h1c000004, 32'h1c000180, 1'b1);
    upd(32'h1c000004, 1'b0, 2'd0, 32'h0);
    look("hys_sat_dn2", 32'h1c000004, 32'h1c000008, 1'b0);

    // Same-cycle hit: ctr 01 -> 10 becomes visible only on the next cycle.
    upd_valid  = 1'b1;
    upd_pc     = 32'h1c000004;
    upd_taken  = 1'b1;
    upd_kind   = 2'd0;
    upd_target = 32'h1c000180;
    look("same_old", 32'h1c000004, 32'h1c000008, 1'b0);
    tick();
    upd_valid = 1'b0;
    look("same_new", 32'h1c000004, 32'h1c000180, 1'b1);

    // Wrap of the fall-through adder and indirect allocation at strong-taken.
    look("wrap", 32'hfffffff8, 32'h00000000, 1'b0);
    upd(32'h1c000040, 1'b1, 2'd2, 32'h1c001000);
    look("jirl_alloc", 32'h1c000040, 32'h1c001000, 1'b1);
    upd(32'h1c000040, 1'b0, 2'd0, 32'h0);
    look("jirl_st_dn", 32'h1c000040, 32'h1c001000, 1'b1);
    upd(32'h1c000048, 1'b1, 2'd3, 32'h1c002000);
    look("kind3_ignored", 32'h1c000048, 32'h1c000050, 1'b0);
    upd(32'h1c000060, 1'b0, 2'd0, 32'h1c003000);
    look("miss_nt_nowrite", 32'h1c000060, 32'h1c000068, 1'b0);

    // Reset mid-operation restarts the sweep and clears trained entries.
    rstn = 1'b0;
    #1;
    chk("rst2_ready", {31'd0, bpu_ready}, 32'd0);
    look("rst2_tk", 32'h1c000004, 32'h1c000008, 1'b0);
    rstn = 1'b1;
    init_sweep("rst2");
    look("rst2_cleared", 32'h1c000004, 32'h1c000008, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
